display_tiempo: RTL and testbench



---
 rtl/display_pkg.sv | 55 +++++
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/display_tiempo.sv | 165 ++++++++++++++++
 tb/tb_display_tiempo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the time-of-day display: state encodings, the
// digit count, the blank segment pattern and the combinational helpers
// used by the BCD converter and the scan driver.
package display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Phases of the per-field double-dabble converter
  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT,
    CONV_STORE
  } conv_state_e;

  // Phases of the field sequencer in the top level
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CONVERT,
    SEQ_COMMIT
  } seq_state_e;

  // One double-dabble step: add 3 to every nibble that is 5 or more,
  // then shift the scratch left, bringing in the next binary bit.
  function automatic logic [7:0] dabble_step(input logic [7:0] scratch,
                                             input logic       in_bit);
    logic [7:0] adj;
    adj = scratch;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    return (adj << 1) | {7'b0, in_bit};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter for one 6-bit binary field.
// A start pulse (accepted while idle or in the store cycle, so fields can
// be chained back to back) leads to one LOAD cycle, six SHIFT cycles and a
// STORE cycle during which done is high and tens/units hold the result.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  conv_state_e state;
  logic [2:0]  shift_cnt;
  logic [7:0]  scratch;
  logic [5:0]  work;

  // Converter state machine and datapath; the binary field is sampled in
  // LOAD so the caller only needs it stable from the cycle after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CONV_IDLE;
      shift_cnt <= 3'd0;
      scratch   <= 8'd0;
      work      <= 6'd0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) state <= CONV_LOAD;
        end
        CONV_LOAD: begin
          scratch   <= 8'd0;
          work      <= bin;
          shift_cnt <= 3'd0;
          state     <= CONV_SHIFT;
        end
        CONV_SHIFT: begin
          scratch   <= dabble_step(scratch, work[5]);
          work      <= {work[4:0], 1'b0};
          shift_cnt <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd5) state <= CONV_STORE;
        end
        CONV_STORE: begin
          state <= start ? CONV_LOAD : CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

  assign done  = (state == CONV_STORE);
  assign tens  = scratch[7:4];
  assign units = scratch[3:0];

endmodule

// File: rtl/display_tiempo.sv
// Six-digit multiplexed 7-segment driver for HH MM SS.
// Snapshots the binary time whenever it changes, converts sec, min and
// hour to BCD one after another, then commits all six digits at once so
// the display never shows a half-updated time. A prescaler walks the
// digit enables at CLK_FREQ/SCAN_HZ cycles per digit.
// Build option: define DP_BLINK_EN to light the decimal points on the
// HH.MM.SS separator digits while displayed seconds-units is even;
// otherwise the decimal point stays off.
module display_tiempo
  import display_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int SCAN_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DWELL - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  seq_state_e seq_state;
  logic [1:0]  field;
  logic [16:0] snapshot;
  logic        snap_valid;
  logic [16:0] current;
  logic        change_start;

  logic        conv_start;
  logic [5:0]  conv_bin;
  logic        conv_done;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_units;

  logic [NUM_DIGITS-1:0][3:0] pending;
  logic [NUM_DIGITS-1:0][3:0] shown;

  logic [PW-1:0] presc;
  logic [2:0]    digit_idx;

  assign current = {hour, min, sec};

  // A new conversion is due whenever nothing valid has been captured yet
  // or the live time no longer matches the last snapshot.
  assign change_start = (seq_state == SEQ_IDLE) &&
                        (!snap_valid || (current != snapshot));

  // Kick the converter on the start cycle and again from each field's
  // store cycle until the hour field has been done.
  assign conv_start = change_start ||
                      ((seq_state == SEQ_CONVERT) && conv_done && (field != 2'd2));

  // Field order is sec, min, hour; all fields come from the snapshot so
  // input changes during a conversion cannot mix two different times.
  always_comb begin
    conv_bin = 6'd0;
    case (field)
      2'd0:    conv_bin = snapshot[5:0];
      2'd1:    conv_bin = snapshot[11:6];
      2'd2:    conv_bin = {1'b0, snapshot[16:12]};
      default: conv_bin = 6'd0;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .tens  (conv_tens),
    .units (conv_units)
  );

  // Field sequencer: capture snapshot, collect each field's digits into
  // the pending bank, then spend one cycle committing them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_state  <= SEQ_IDLE;
      field      <= 2'd0;
      snapshot   <= 17'd0;
      snap_valid <= 1'b0;
      busy       <= 1'b0;
      pending    <= '0;
    end else begin
      case (seq_state)
        SEQ_IDLE: begin
          if (change_start) begin
            snapshot   <= current;
            snap_valid <= 1'b1;
            busy       <= 1'b1;
            field      <= 2'd0;
            seq_state  <= SEQ_CONVERT;
          end
        end
        SEQ_CONVERT: begin
          if (conv_done) begin
            pending[{field, 1'b0}] <= conv_units;
            pending[{field, 1'b1}] <= conv_tens;
            if (field == 2'd2) begin
              seq_state <= SEQ_COMMIT;
            end else begin
              field <= field + 2'd1;
            end
          end
        end
        SEQ_COMMIT: begin
          busy      <= 1'b0;
          seq_state <= SEQ_IDLE;
        end
        default: seq_state <= SEQ_IDLE;
      endcase
    end
  end

  // Displayed digit bank, replaced as a whole during the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown <= '0;
    end else if (seq_state == SEQ_COMMIT) begin
      shown <= pending;
    end
  end

  // Dwell prescaler and digit index, stepping 0..5 and wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= '0;
      digit_idx <= 3'd0;
    end else if (presc == PRESC_MAX) begin
      presc     <= '0;
      digit_idx <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered pin drivers derived from the current digit index, so the
  // board sees glitch-free enables and segments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(6'b000001 << digit_idx);
      seg <= bcd_to_seg(shown[digit_idx]);
`ifdef DP_BLINK_EN
      dp  <= ~(((digit_idx == 3'd2) || (digit_idx == 3'd4)) && !shown[0][0]);
`else
      dp  <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_display_tiempo.sv
// Self-checking bench for display_tiempo with a 10-cycle digit dwell.
// Expected digits come from a vector table; expected pin patterns are
// queued when stimulus is driven and popped when the display is scanned.
module tb_display_tiempo;

  logic       clk;
  logic       rst;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [23:0] dig;
  } vec_t;

  typedef struct packed {
    logic [5:0][6:0] seg;
    logic [5:0]      dp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  display_tiempo #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk  (clk),
    .rst  (rst),
    .sec  (sec),
    .min  (min),
    .hour (hour),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] segLut(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a time and queue the pin patterns it should produce
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    hour = v.hour;
    min  = v.min;
    sec  = v.sec;
    for (int d = 0; d < 6; d++) begin
      e.seg[d] = segLut(v.dig[d*4 +: 4]);
`ifdef DP_BLINK_EN
      e.dp[d] = ((d == 2 || d == 4) && !v.dig[0]) ? 1'b0 : 1'b1;
`else
      e.dp[d] = 1'b1;
`endif
    end
    sb.push_back(e);
  endtask

  // Wait for busy to rise and count the negedges it stays high
  task automatic waitConversion(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (!busy && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Pop one expected record and compare every digit as the scan visits it
  task automatic checkOutput();
    exp_t e;
    logic [5:0] want_an;
    int g;
    @(negedge clk);
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int d = 0; d < 6; d++) begin
      want_an = ~(6'b000001 << d);
      g = 0;
      while (an !== want_an && g < 80) begin
        @(negedge clk);
        g++;
      end
      if (an !== want_an) begin
        checkVal($sformatf("scan_timeout_digit%0d", d), {26'd0, an}, {26'd0, want_an});
      end else begin
        checkVal($sformatf("seg_digit%0d", d), {25'd0, seg}, {25'd0, e.seg[d]});
        checkVal($sformatf("dp_digit%0d", d), {31'd0, dp}, {31'd0, e.dp[d]});
      end
    end
  endtask

  initial begin
    int n;
    int busy_cnt;
    int g;
    int dwell_err[6];
    exp_t e;

    vecs[0] = '{hour: 5'd23, min: 6'd59, sec: 6'd58, dig: 24'h235958};
    vecs[1] = '{hour: 5'd31, min: 6'd0,  sec: 6'd63, dig: 24'h310063};
    vecs[2] = '{hour: 5'd12, min: 6'd34, sec: 6'd56, dig: 24'h123456};
    vecs[3] = '{hour: 5'd9,  min: 6'd5,  sec: 6'd7,  dig: 24'h090507};
    vecs[4] = '{hour: 5'd10, min: 6'd0,  sec: 6'd10, dig: 24'h100010};
    vecs[5] = '{hour: 5'd10, min: 6'd0,  sec: 6'd11, dig: 24'h100011};

    // Reset with all-zero time
    rst = 1'b0;
    hour = 5'd0;
    min = 6'd0;
    sec = 6'd0;
    repeat (3) @(negedge clk);
    checkVal("reset_an", {26'd0, an}, 32'h3F);
    checkVal("reset_seg", {25'd0, seg}, 32'h7F);
    checkVal("reset_dp", {31'd0, dp}, 32'd1);
    checkVal("reset_busy", {31'd0, busy}, 32'd0);

    // Release: first conversion starts at once, scan walks 10 cycles/digit
    rst = 1'b1;
    busy_cnt = 0;
    for (int d = 0; d < 6; d++) dwell_err[d] = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (an !== ~(6'b000001 << ((k - 1) / 10)) || seg !== 7'h40)
        dwell_err[(k - 1) / 10]++;
    end
    checkVal("post_reset_busy_cycles", busy_cnt, 32'd25);
    for (int d = 0; d < 6; d++)
      checkVal($sformatf("post_reset_dwell_digit%0d", d), dwell_err[d], 32'd0);

    // Table of times, including out-of-range values and dp blink patterns
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      waitConversion(n);
      checkVal($sformatf("busy_cycles_vec%0d", i), n, 32'd25);
      checkOutput();
    end

    // Input change mid-conversion: align so digit 0 is shown between commits
    g = 0;
    while (an === 6'b111110 && g < 80) begin @(negedge clk); g++; end
    while (an !== 6'b111110 && g < 160) begin @(negedge clk); g++; end
    checkVal("align_digit0", {26'd0, an}, 32'h3E);
    repeat (30) @(negedge clk);
    applyStimulus('{hour: 5'd23, min: 6'd59, sec: 6'd58, dig: 24'h235958});
    repeat (5) @(negedge clk);
    applyStimulus('{hour: 5'd23, min: 6'd59, sec: 6'd59, dig: 24'h235959});
    repeat (21) @(negedge clk);
    checkVal("busy_low_after_first_commit", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkVal("busy_restart", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge clk);
    checkVal("first_commit_digit0_an", {26'd0, an}, 32'h3E);
    e = sb.pop_front();
    checkVal("first_commit_sec_units", {25'd0, seg}, {25'd0, e.seg[0]});
    checkVal("first_commit_dp", {31'd0, dp}, {31'd0, e.dp[0]});
    waitConversion(n);
    checkVal("second_conv_remaining", n, 32'd20);
    checkOutput();

    // Reset asserted mid-shift: outputs clear immediately, display rebuilds
    applyStimulus(vecs[3]);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkVal("midreset_an", {26'd0, an}, 32'h3F);
    checkVal("midreset_seg", {25'd0, seg}, 32'h7F);
    checkVal("midreset_busy", {31'd0, busy}, 32'd0);
    checkVal("midreset_dp", {31'd0, dp}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    waitConversion(n);
    checkVal("rebuild_busy_cycles", n, 32'd25);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
